// File: rtl/axi_w_pkg.sv
// Shared types for the AXI W-channel beat generator: beat payload and burst FSM states.
// AXI_DATA_WIDTH mirrors the SoC-wide data width (salyut1_soc_config).
package axi_w_pkg;

  localparam int AXI_DATA_WIDTH = 64;

  typedef struct packed {
    logic [AXI_DATA_WIDTH-1:0] data;
    logic [7:0]                strb;
  } w_beat_t;

  typedef enum logic {
    W_IDLE,
    W_BURST
  } w_state_e;

endpackage

// File: rtl/sys_axi_w.sv
// AXI write-data channel bundle; master drives payload/valid, slave drives wready.
interface sys_axi_w;
  import axi_w_pkg::*;

  logic [AXI_DATA_WIDTH-1:0] wdata;
  logic [7:0]                wstrb;
  logic                      wlast;
  logic                      wvalid;
  logic                      wready;

  modport master (output wdata, output wstrb, output wlast, output wvalid, input wready);
  modport slave  (input wdata, input wstrb, input wlast, input wvalid, output wready);
endinterface

// File: rtl/axi_w_fifo.sv
// Sync beat FIFO; write-to-read latency 1 cycle (no bypass), flags from registered pointers.
// Push ignored when full, pop ignored when empty; a pop frees its slot only next cycle.
module axi_w_fifo
  import axi_w_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk_i,
  input  logic    srst_i,
  input  logic    push_i,
  input  w_beat_t din_i,
  input  logic    pop_i,
  output w_beat_t dout_o,
  output logic    full_o,
  output logic    empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  w_beat_t     mem_q [DEPTH];
  logic        do_push, do_pop;

  // Extra MSB distinguishes full from empty when the index bits match.
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    do_push  = push_i && !full_o;
    do_pop   = pop_i && !empty_o;
    wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
    rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= din_i;
    end
  end

endmodule

// File: rtl/axi_w_beat_gen.sv
// W-channel source: buffers write beats, emits one AXI W burst of len+1 beats per command with wlast.
// Latency wr->W 1 cycle min; W holds under wready=0; wr_ready_o = FIFO not full; cmd accepted on last beat.
module axi_w_beat_gen
  import axi_w_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int LEN_W      = 8
) (
  input  logic                      clk_i,
  input  logic                      srst_i,
  input  logic                      cmd_valid_i,
  output logic                      cmd_ready_o,
  input  logic [LEN_W-1:0]          cmd_len_i,
  input  logic                      wr_valid_i,
  output logic                      wr_ready_o,
  input  logic [AXI_DATA_WIDTH-1:0] wr_data_i,
  input  logic [7:0]                wr_strb_i,
  output logic                      busy_o,
  sys_axi_w.master                  axi_w
);

  w_state_e         state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  w_beat_t          head;
  w_beat_t          din;
  logic             full, empty;
  logic             push, pop;
  logic             wvalid, wlast;

  assign din.data   = wr_data_i;
  assign din.strb   = wr_strb_i;
  assign wr_ready_o = !full && !srst_i;
  assign push       = wr_valid_i && wr_ready_o;

  axi_w_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .srst_i  (srst_i),
    .push_i  (push),
    .din_i   (din),
    .pop_i   (pop),
    .dout_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cmd_ready_o = 1'b0;
    wvalid      = 1'b0;
    wlast       = 1'b0;
    pop         = 1'b0;
    case (state_q)
      W_IDLE: begin
        cmd_ready_o = 1'b1;
        if (cmd_valid_i) begin
          cnt_d   = cmd_len_i;
          state_d = W_BURST;
        end
      end
      W_BURST: begin
        wvalid = !empty;
        wlast  = (cnt_q == '0);
        if (wvalid && axi_w.wready) begin
          pop   = 1'b1;
          cnt_d = cnt_q - LEN_W'(1);
          // Last beat leaving frees the FSM; take the next command in the same cycle.
          if (wlast) begin
            cmd_ready_o = 1'b1;
            if (cmd_valid_i) begin
              cnt_d = cmd_len_i;
            end else begin
              state_d = W_IDLE;
            end
          end
        end
      end
      default: state_d = W_IDLE;
    endcase
    if (srst_i) begin
      cmd_ready_o = 1'b0;
      wvalid      = 1'b0;
      wlast       = 1'b0;
      pop         = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q <= W_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign axi_w.wvalid = wvalid;
  assign axi_w.wlast  = wlast;
  assign axi_w.wdata  = head.data;
  assign axi_w.wstrb  = head.strb;
  assign busy_o       = !srst_i && ((state_q == W_BURST) || !empty);

endmodule

// File: tb/tb_axi_w_beat_gen.sv
// Bench for axi_w_beat_gen: queue-based reference model checked every cycle plus directed scenarios.
module tb_axi_w_beat_gen;
  import axi_w_pkg::*;

  localparam int DEPTH = 4;
  localparam int LEN_W = 8;

  logic        clk = 1'b0;
  logic        srst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [7:0]  cmd_len = '0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [63:0] wr_data = '0;
  logic [7:0]  wr_strb = '0;
  logic        busy;
  logic        wready = 1'b0;

  always #5 clk = ~clk;

  sys_axi_w w_if ();
  assign w_if.wready = wready;

  axi_w_beat_gen #(
    .FIFO_DEPTH (DEPTH),
    .LEN_W      (LEN_W)
  ) dut (
    .clk_i       (clk),
    .srst_i      (srst),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_len_i   (cmd_len),
    .wr_valid_i  (wr_valid),
    .wr_ready_o  (wr_ready),
    .wr_data_i   (wr_data),
    .wr_strb_i   (wr_strb),
    .busy_o      (busy),
    .axi_w       (w_if)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: beats buffered, current burst remaining count, log of W handshakes.
  logic [71:0] m_fifo[$];
  bit          m_active = 1'b0;
  int          m_left   = 0;
  logic [72:0] hs_log[$];
  bit          prev_stall = 1'b0;
  logic [73:0] prev_out;

  always @(negedge clk) begin : model_blk
    int   sz;
    logic ev, elast, whs, last_hs, exp_cr, cacc;
    if (srst) begin
      chk("rst_wvalid", w_if.wvalid, 1'b0);
      chk("rst_cmd_ready", cmd_ready, 1'b0);
      chk("rst_wr_ready", wr_ready, 1'b0);
      chk("rst_busy", busy, 1'b0);
      m_fifo.delete();
      m_active   = 1'b0;
      m_left     = 0;
      prev_stall = 1'b0;
    end else begin
      sz    = m_fifo.size();
      ev    = m_active && (sz > 0);
      elast = m_active && (m_left == 1);
      chk("wvalid", w_if.wvalid, ev);
      chk("wr_ready", wr_ready, sz < DEPTH);
      chk("busy", busy, m_active || (sz > 0));
      if (prev_stall)
        chk("stall_hold", {w_if.wvalid, w_if.wlast, w_if.wdata, w_if.wstrb}, prev_out);
      if (ev) begin
        chk("wbeat", {w_if.wdata, w_if.wstrb}, m_fifo[0]);
        chk("wlast", w_if.wlast, elast);
      end
      whs     = ev && wready;
      last_hs = whs && elast;
      exp_cr  = !m_active || last_hs;
      chk("cmd_ready", cmd_ready, exp_cr);
      cacc       = cmd_valid && exp_cr;
      prev_stall = ev && !wready;
      prev_out   = {w_if.wvalid, w_if.wlast, w_if.wdata, w_if.wstrb};
      if (whs) begin
        hs_log.push_back({elast, m_fifo[0]});
        void'(m_fifo.pop_front());
        m_left--;
        if (m_left == 0) m_active = 1'b0;
      end
      if (cacc) begin
        m_active = 1'b1;
        m_left   = int'(cmd_len) + 1;
      end
      if (wr_valid && (sz < DEPTH)) m_fifo.push_back({wr_data, wr_strb});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [63:0] d, input logic [7:0] s);
    wr_valid = 1'b1;
    wr_data  = d;
    wr_strb  = s;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 300) begin
      tick();
      n++;
    end
    chk(name, busy, 1'b0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [3:0]  pat;
    logic [72:0] e;
    int          base, npush, cyc;
    bit          acc, cacc, dacc, done;
    int          lens[20];
    int          nb, ci, di;

    // Reset state
    srst = 1'b1;
    tick();
    tick();
    srst = 1'b0;

    // 1: len=3, 4 beats preloaded, wready=1
    wready = 1'b0;
    for (int i = 0; i < 4; i++) push(64'hA0 + i, 8'hFF);
    cmd_valid = 1'b1; cmd_len = 8'd3; wready = 1'b1;
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t1_wvalid", w_if.wvalid, 1'b1);
      chk("t1_wdata", w_if.wdata, 64'hA0 + i);
      chk("t1_wlast", w_if.wlast, i == 3);
      chk("t1_cmd_ready", cmd_ready, i == 3);
      tick();
    end
    wait_idle("t1_idle");

    // 2: len=0 single beat
    cmd_valid = 1'b1; cmd_len = 8'd0;
    wr_valid = 1'b1; wr_data = 64'hDEAD_BEEF; wr_strb = 8'h0F;
    tick();
    cmd_valid = 1'b0; wr_valid = 1'b0;
    @(negedge clk);
    chk("t2_wvalid", w_if.wvalid, 1'b1);
    chk("t2_wdata", w_if.wdata, 64'hDEAD_BEEF);
    chk("t2_wstrb", w_if.wstrb, 8'h0F);
    chk("t2_wlast", w_if.wlast, 1'b1);
    tick();
    @(negedge clk);
    chk("t2_busy_after", busy, 1'b0);
    chk("t2_wvalid_after", w_if.wvalid, 1'b0);
    tick();

    // 3: len=7, wready 1-0-0-1 then random
    base = hs_log.size();
    npush = 0;
    pat = 4'b1001;
    cmd_valid = 1'b1; cmd_len = 8'd7;
    for (int k = 0; k < 300; k++) begin
      wr_valid = (npush < 8);
      wr_data  = 64'hC0 + npush;
      wr_strb  = 8'hFF;
      wready   = (k < 4) ? pat[3-k] : 1'($urandom_range(0, 1));
      @(negedge clk);
      acc = wr_valid && wr_ready;
      tick();
      cmd_valid = 1'b0;
      if (acc) npush++;
      if (npush == 8 && !busy) break;
    end
    wr_valid = 1'b0; wready = 1'b1;
    chk("t3_count", hs_log.size() - base, 8);
    for (int i = 0; i < 8; i++) begin
      e[72]   = (i == 7);
      e[71:8] = 64'hC0 + i;
      e[7:0]  = 8'hFF;
      if (base + i < hs_log.size()) chk("t3_beat", hs_log[base+i], e);
    end

    // 4: two back-to-back len=1 bursts
    wready = 1'b0;
    for (int i = 0; i < 4; i++) push(64'hD0 + i, 8'h33);
    cmd_valid = 1'b1; cmd_len = 8'd1; wready = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t4_wvalid", w_if.wvalid, 1'b1);
      chk("t4_wdata", w_if.wdata, 64'hD0 + i);
      chk("t4_wlast", w_if.wlast, (i == 1) || (i == 3));
      chk("t4_cmd_ready", cmd_ready, (i == 1) || (i == 3));
      tick();
      if (i == 1) cmd_valid = 1'b0;
    end
    wait_idle("t4_idle");

    // 5: fill FIFO with wready=0, 5th beat accepted one cycle after first W handshake
    wready = 1'b0; wr_valid = 1'b1; wr_strb = 8'h5A;
    for (int i = 0; i < 4; i++) begin
      wr_data = 64'hE0 + i;
      @(negedge clk);
      chk("t5_wr_ready_fill", wr_ready, 1'b1);
      tick();
    end
    wr_data = 64'hE4;
    @(negedge clk);
    chk("t5_wr_ready_full", wr_ready, 1'b0);
    tick();
    cmd_valid = 1'b1; cmd_len = 8'd4; wready = 1'b1;
    @(negedge clk);
    chk("t5_full_cmd", wr_ready, 1'b0);
    tick();
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("t5_first_hs_wvalid", w_if.wvalid, 1'b1);
    chk("t5_first_hs_wr_ready", wr_ready, 1'b0);
    tick();
    @(negedge clk);
    chk("t5_slot_freed", wr_ready, 1'b1);
    tick();
    wr_valid = 1'b0;
    wait_idle("t5_idle");

    // 6: reset during beat 2 of 4, then a fresh len=1 burst
    wready = 1'b0;
    for (int i = 0; i < 4; i++) push(64'hF0 + i, 8'hFF);
    cmd_valid = 1'b1; cmd_len = 8'd3; wready = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    srst = 1'b1;
    tick();
    srst = 1'b0;
    @(negedge clk);
    chk("t6_wvalid", w_if.wvalid, 1'b0);
    chk("t6_busy", busy, 1'b0);
    chk("t6_wr_ready", wr_ready, 1'b1);
    chk("t6_cmd_ready", cmd_ready, 1'b1);
    tick();
    base = hs_log.size();
    cmd_valid = 1'b1; cmd_len = 8'd1;
    push(64'h11, 8'h01);
    cmd_valid = 1'b0;
    push(64'h12, 8'h03);
    wait_idle("t6_idle");
    chk("t6_count", hs_log.size() - base, 2);
    if (hs_log.size() >= base + 2) begin
      chk("t6_beat0", hs_log[base], {1'b0, 64'h11, 8'h01});
      chk("t6_beat1", hs_log[base+1], {1'b1, 64'h12, 8'h03});
    end

    // Random traffic
    nb = 0;
    for (int i = 0; i < 20; i++) begin
      lens[i] = $urandom_range(0, 7);
      nb += lens[i] + 1;
    end
    base = hs_log.size();
    ci = 0; di = 0; done = 1'b0;
    for (cyc = 0; cyc < 4000 && !done; cyc++) begin
      if (!cmd_valid && ci < 20 && $urandom_range(0, 2) == 0) begin
        cmd_valid = 1'b1;
        cmd_len   = 8'(lens[ci]);
      end
      if (!wr_valid && di < nb && $urandom_range(0, 1) == 1) begin
        wr_valid = 1'b1;
        wr_data  = {$urandom, $urandom};
        wr_strb  = 8'($urandom);
      end
      wready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      cacc = cmd_valid && cmd_ready;
      dacc = wr_valid && wr_ready;
      tick();
      if (cacc) begin ci++; cmd_valid = 1'b0; end
      if (dacc) begin di++; wr_valid = 1'b0; end
      done = (ci == 20) && (di == nb) && !busy;
    end
    chk("rnd_done", done, 1'b1);
    chk("rnd_count", hs_log.size() - base, nb);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
